hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NPORT, default 3, giving the number of ID source-operand ports (Rn, Rm, Rd-for-store).
REQ-002 The block SHALL have parameter RAW, default 4, giving the register-address width (16 registers).
REQ-003 The block SHALL have parameter MEM_LAT, default 1, legal range 1..4, giving load latency in MEM-stage cycles.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 R  in  1  reset, synchronous, active-high.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 id_rs  in  NPORT*RAW  source register numbers; port k at bits [k*RAW +: RAW].
REQ-008 id_rs_used  in  NPORT  port k is actually read by the ID instruction.
REQ-009 id_rd  in  RAW  destination register (already muxed to 14 for BL).
REQ-010 id_rf_we  in  1  ID instruction writes the register file.
REQ-011 id_load  in  1  ID instruction is a load.
REQ-012 flush  in  1  taken branch; kill the instruction currently in ID.
REQ-013 fw_sel  out  2*NPORT  per-port operand source: 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
REQ-014 stall  out  1  hold PC and IF/ID (drives PC/IF_ID LE low).
REQ-015 bubble  out  1  select NOP at the CU mux for the entry into EX.
REQ-016 freeze  out  1  hold all of ID/EX, EX/MEM and MEM/WB (multi-cycle load).

Function
REQ-017 The block SHALL keep three internal stage entries, EX, MEM and WB, each holding {valid, rd, we, load}.
REQ-018 On a non-frozen edge, WB<=MEM and MEM<=EX. EX<=ID entry when id_valid & !stall & !flush; otherwise EX<=invalid.
REQ-019 Port k match on stage S: id_rs_used[k] & S.valid & S.we & S.rd==rs_k & rs_k!=15.
REQ-020 fw_sel[k] SHALL take the youngest matching stage, priority EX > MEM > WB; with no match it SHALL be 0. It is combinational from current state and inputs.
REQ-021 stall SHALL assert when id_valid & !flush and any port matches EX with EX.load=1 (load-use). It SHALL also assert whenever freeze=1.
REQ-022 bubble SHALL equal (stall | flush) & !freeze.
REQ-023 Latency counter lat_cnt, width 2: on a non-frozen edge where the entry moving into MEM is a valid load, lat_cnt<=MEM_LAT-1. While lat_cnt!=0, freeze=1 and lat_cnt decrements by 1 per edge.
REQ-024 With MEM_LAT=1, freeze SHALL never assert.
REQ-025 During freeze, all stage entries SHALL hold, fw_sel SHALL still be computed, and stall=1.
REQ-026 flush and a load-use stall in the same cycle: flush wins. stall=0 unless frozen, EX receives a bubble, and the PC advances to the target.
REQ-027 Register 15 SHALL never be forwarded, and writes to rd=15 SHALL never match.
REQ-028 A load-use hazard SHALL cost exactly 1 stall cycle plus MEM_LAT-1 freeze cycles; after that, forwarding comes from MEM (when MEM_LAT=1) or from WB.

Reset
REQ-029 While R=1 at a clock edge, all stage entries SHALL be set invalid and lat_cnt<=0. This applies mid-freeze too.
REQ-030 Reset values: fw_sel=0, stall=0, bubble=0, freeze=0 from the first cycle after R is sampled high.

Structure
REQ-031 A shared package SHALL hold fw_sel encodings FW_RF/FW_EX/FW_MEM/FW_WB, the stage-entry typedef and PC_REG=15.
REQ-032 Exactly one sub-module SHALL be used: hs_match, which does the per-port compare against the three stages and priority-encodes to fw_sel. It SHALL be instantiated NPORT times via generate.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- ADD r1 then SUB r2,r1,r3 -> fw_sel[port0]=1 (EX), stall=0.
- LDR r1 then ADD r2,r1,r1 with MEM_LAT=1 -> one cycle stall=1, bubble=1; next cycle fw_sel ports 0 and 1 = 2 (MEM).
- LDR r4 then STR r4 with MEM_LAT=3 -> stall 1 cycle, freeze 2 cycles; stage entries unchanged during freeze; then fw_sel=3 (WB).
- Load-use with flush=1 in the same cycle -> stall=0, bubble=1, EX invalid on the next edge.
- r1 written in both EX and WB -> fw_sel=1; rs=15 with EX.rd=15 -> fw_sel=0.
- R=1 asserted during freeze (MEM_LAT=4) -> next cycle freeze=0, stall=0, all fw_sel=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: forwarding-source codes
// and the per-stage {valid, rd, we, load} tracking entry.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FW_RF  = 2'd0,
    FW_EX  = 2'd1,
    FW_MEM = 2'd2,
    FW_WB  = 2'd3
  } fw_sel_e;

  // Entries store rd at a fixed width so the struct is independent of RAW.
  localparam int unsigned RD_W = 8;
  localparam logic [RD_W-1:0] PC_REG = 8'd15;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            load;
  } stage_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hs_match: compare one source operand against the EX/MEM/WB entries and
// priority-encode the youngest writer into a forwarding select.
module hs_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int RAW = 4
) (
  input  logic [RAW-1:0] rs_i,
  input  logic           used_i,
  input  stage_t         ex_i,
  input  stage_t         mem_i,
  input  stage_t         wb_i,
  output logic [1:0]     sel_o,
  output logic           ex_hit_o
);

  logic [RD_W-1:0] rs_ext;
  logic            cand;
  logic            mem_hit;
  logic            wb_hit;

  assign rs_ext   = RD_W'(rs_i);
  // The PC is never a forwarding candidate, either as source or destination.
  assign cand     = used_i && (rs_ext != PC_REG);
  assign ex_hit_o = cand && ex_i.valid  && ex_i.we  && (ex_i.rd  == rs_ext);
  assign mem_hit  = cand && mem_i.valid && mem_i.we && (mem_i.rd == rs_ext);
  assign wb_hit   = cand && wb_i.valid  && wb_i.we  && (wb_i.rd  == rs_ext);

  always_comb begin
    sel_o = FW_RF;
    if (ex_hit_o)     sel_o = FW_EX;
    else if (mem_hit) sel_o = FW_MEM;
    else if (wb_hit)  sel_o = FW_WB;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks EX/MEM/WB destinations, selects operand forwarding,
// and generates stall/bubble/freeze for load-use and multi-cycle loads.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NPORT   = 3,
  parameter int RAW     = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic                   id_valid,
  input  logic [NPORT*RAW-1:0]   id_rs,
  input  logic [NPORT-1:0]       id_rs_used,
  input  logic [RAW-1:0]         id_rd,
  input  logic                   id_rf_we,
  input  logic                   id_load,
  input  logic                   flush,
  output logic [2*NPORT-1:0]     fw_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic                   freeze
);

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d, mem_d, wb_d;
  stage_t id_entry;
  logic [1:0]       lat_q, lat_d;
  logic [NPORT-1:0] ex_hit;
  logic             load_use;

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    hs_match #(.RAW(RAW)) u_match (
      .rs_i     (id_rs[k*RAW +: RAW]),
      .used_i   (id_rs_used[k]),
      .ex_i     (ex_q),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .sel_o    (fw_sel[2*k +: 2]),
      .ex_hit_o (ex_hit[k])
    );
  end

  assign id_entry = '{valid: 1'b1, rd: RD_W'(id_rd), we: id_rf_we, load: id_load};
  assign freeze   = (lat_q != 2'd0);
  // A flush kills the consumer, so the load-use hazard no longer exists.
  assign load_use = id_valid && !flush && ex_q.load && (|ex_hit);
  assign stall    = load_use || freeze;
  assign bubble   = (stall || flush) && !freeze;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    lat_d = lat_q;
    if (freeze) begin
      lat_d = lat_q - 2'd1;
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (id_valid && !stall && !flush) ? id_entry : '0;
      lat_d = (ex_q.valid && ex_q.load) ? 2'(MEM_LAT - 1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      lat_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      lat_q <= lat_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; three instances (MEM_LAT 1/3/4) share
// the ID-side stimulus, each scenario resets first and checks one instance.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        R;
  logic        id_valid;
  logic [11:0] id_rs;
  logic [2:0]  id_rs_used;
  logic [3:0]  id_rd;
  logic        id_rf_we;
  logic        id_load;
  logic        flush;

  logic [5:0] u1_fw, u3_fw, u4_fw;
  logic       u1_stall, u3_stall, u4_stall;
  logic       u1_bubble, u3_bubble, u4_bubble;
  logic       u1_freeze, u3_freeze, u4_freeze;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NPORT(3), .RAW(4), .MEM_LAT(1)) u1 (
    .clk(clk), .R(R), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_load(id_load), .flush(flush),
    .fw_sel(u1_fw), .stall(u1_stall), .bubble(u1_bubble), .freeze(u1_freeze));

  hazard_scoreboard #(.NPORT(3), .RAW(4), .MEM_LAT(3)) u3 (
    .clk(clk), .R(R), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_load(id_load), .flush(flush),
    .fw_sel(u3_fw), .stall(u3_stall), .bubble(u3_bubble), .freeze(u3_freeze));

  hazard_scoreboard #(.NPORT(3), .RAW(4), .MEM_LAT(4)) u4 (
    .clk(clk), .R(R), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_load(id_load), .flush(flush),
    .fw_sel(u4_fw), .stall(u4_stall), .bubble(u4_bubble), .freeze(u4_freeze));

  task automatic set_id(input logic v, input logic [3:0] rs0, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [2:0] used, input logic [3:0] rd,
                        input logic we, input logic ld);
    id_valid   = v;
    id_rs      = {rs2, rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_rf_we   = we;
    id_load    = ld;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    R = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
    edge_step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    vectors++; if ({u1_fw, u3_fw, u4_fw} !== 18'd0) begin miscompares++; $display("FAIL reset_fw got %h want 0", {u1_fw, u3_fw, u4_fw}); end
    vectors++; if ({u1_stall, u3_stall, u4_stall} !== 3'b000) begin miscompares++; $display("FAIL reset_stall got %b want 000", {u1_stall, u3_stall, u4_stall}); end
    vectors++; if ({u1_bubble, u3_bubble, u4_bubble} !== 3'b000) begin miscompares++; $display("FAIL reset_bubble got %b want 000", {u1_bubble, u3_bubble, u4_bubble}); end
    vectors++; if ({u1_freeze, u3_freeze, u4_freeze} !== 3'b000) begin miscompares++; $display("FAIL reset_freeze got %b want 000", {u1_freeze, u3_freeze, u4_freeze}); end
  endtask

  // ADD r1,r2,r3 ; SUB r2,r1,r3
  task automatic test_ex_forward();
    do_reset();
    set_id(1'b1, 4'd2, 4'd3, 4'd0, 3'b011, 4'd1, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b000000) begin miscompares++; $display("FAIL exfwd_first_fw got %b want 000000", u1_fw); end
    edge_step();
    set_id(1'b1, 4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b000001) begin miscompares++; $display("FAIL exfwd_fw got %b want 000001", u1_fw); end
    vectors++; if (u1_stall !== 1'b0) begin miscompares++; $display("FAIL exfwd_stall got %b want 0", u1_stall); end
    vectors++; if (u1_bubble !== 1'b0) begin miscompares++; $display("FAIL exfwd_bubble got %b want 0", u1_bubble); end
  endtask

  // LDR r1,[r2] ; ADD r2,r1,r1 with MEM_LAT=1
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1);
    edge_step();
    set_id(1'b1, 4'd1, 4'd1, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", u1_stall); end
    vectors++; if (u1_bubble !== 1'b1) begin miscompares++; $display("FAIL lu_bubble got %b want 1", u1_bubble); end
    vectors++; if (u1_fw !== 6'b000101) begin miscompares++; $display("FAIL lu_fw_ex got %b want 000101", u1_fw); end
    edge_step();
    settle();
    vectors++; if (u1_stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_after got %b want 0", u1_stall); end
    vectors++; if (u1_bubble !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_after got %b want 0", u1_bubble); end
    vectors++; if (u1_freeze !== 1'b0) begin miscompares++; $display("FAIL lu_freeze_lat1 got %b want 0", u1_freeze); end
    vectors++; if (u1_fw !== 6'b001010) begin miscompares++; $display("FAIL lu_fw_mem got %b want 001010", u1_fw); end
  endtask

  // LDR r4,[r5] ; STR r4,[r5] with MEM_LAT=3, then a reader of r4 one slot later
  task automatic test_multicycle_load();
    do_reset();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 4'd4, 1'b1, 1'b1);
    edge_step();
    set_id(1'b1, 4'd5, 4'd0, 4'd4, 3'b101, 4'd0, 1'b0, 1'b0);
    settle();
    vectors++; if ({u3_stall, u3_bubble, u3_freeze} !== 3'b110) begin miscompares++; $display("FAIL mc_stall_cycle got %b want 110", {u3_stall, u3_bubble, u3_freeze}); end
    vectors++; if (u3_fw !== 6'b010000) begin miscompares++; $display("FAIL mc_fw_ex got %b want 010000", u3_fw); end
    for (int i = 0; i < 2; i++) begin
      edge_step();
      settle();
      vectors++; if ({u3_stall, u3_bubble, u3_freeze} !== 3'b101) begin miscompares++; $display("FAIL mc_freeze_%0d got %b want 101", i, {u3_stall, u3_bubble, u3_freeze}); end
      vectors++; if (u3_fw !== 6'b100000) begin miscompares++; $display("FAIL mc_fw_frozen_%0d got %b want 100000", i, u3_fw); end
    end
    edge_step();
    settle();
    vectors++; if ({u3_stall, u3_bubble, u3_freeze} !== 3'b000) begin miscompares++; $display("FAIL mc_release got %b want 000", {u3_stall, u3_bubble, u3_freeze}); end
    vectors++; if (u3_fw !== 6'b100000) begin miscompares++; $display("FAIL mc_fw_release got %b want 100000", u3_fw); end
    edge_step();
    set_id(1'b1, 4'd4, 4'd0, 4'd0, 3'b011, 4'd6, 1'b1, 1'b0);
    settle();
    vectors++; if (u3_fw !== 6'b000011) begin miscompares++; $display("FAIL mc_fw_wb got %b want 000011", u3_fw); end
    vectors++; if (u3_stall !== 1'b0) begin miscompares++; $display("FAIL mc_stall_wb got %b want 0", u3_stall); end
  endtask

  // Load-use coinciding with a taken branch
  task automatic test_flush();
    do_reset();
    set_id(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1);
    edge_step();
    set_id(1'b1, 4'd1, 4'd1, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    vectors++; if (u1_stall !== 1'b0) begin miscompares++; $display("FAIL fl_stall got %b want 0", u1_stall); end
    vectors++; if (u1_bubble !== 1'b1) begin miscompares++; $display("FAIL fl_bubble got %b want 1", u1_bubble); end
    edge_step();
    flush = 1'b0;
    set_id(1'b1, 4'd2, 4'd1, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b001000) begin miscompares++; $display("FAIL fl_ex_killed got %b want 001000", u1_fw); end
    vectors++; if (u1_stall !== 1'b0) begin miscompares++; $display("FAIL fl_stall_next got %b want 0", u1_stall); end
  endtask

  // r1 in EX and WB, r5 in MEM; then the PC register as destination
  task automatic test_priority_pc();
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
    edge_step();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b0);
    edge_step();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
    edge_step();
    set_id(1'b1, 4'd1, 4'd5, 4'd1, 3'b011, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b001001) begin miscompares++; $display("FAIL prio_fw got %b want 001001", u1_fw); end
    set_id(1'b1, 4'd1, 4'd5, 4'd1, 3'b000, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b000000) begin miscompares++; $display("FAIL unused_fw got %b want 000000", u1_fw); end
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b1);
    edge_step();
    set_id(1'b1, 4'd15, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u1_fw !== 6'b000000) begin miscompares++; $display("FAIL pc_fw got %b want 000000", u1_fw); end
    vectors++; if (u1_stall !== 1'b0) begin miscompares++; $display("FAIL pc_stall got %b want 0", u1_stall); end
  endtask

  // LDR r1 ; ADD r2,r1 with MEM_LAT=4, reset while frozen
  task automatic test_reset_in_freeze();
    do_reset();
    set_id(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1);
    edge_step();
    set_id(1'b1, 4'd1, 4'd1, 4'd1, 3'b111, 4'd2, 1'b1, 1'b0);
    settle();
    vectors++; if (u4_stall !== 1'b1) begin miscompares++; $display("FAIL rf_stall got %b want 1", u4_stall); end
    edge_step();
    settle();
    vectors++; if (u4_freeze !== 1'b1) begin miscompares++; $display("FAIL rf_freeze1 got %b want 1", u4_freeze); end
    edge_step();
    settle();
    vectors++; if (u4_freeze !== 1'b1) begin miscompares++; $display("FAIL rf_freeze2 got %b want 1", u4_freeze); end
    R = 1'b1;
    edge_step();
    R = 1'b0;
    settle();
    vectors++; if ({u4_freeze, u4_stall, u4_bubble} !== 3'b000) begin miscompares++; $display("FAIL rf_after got %b want 000", {u4_freeze, u4_stall, u4_bubble}); end
    vectors++; if (u4_fw !== 6'b000000) begin miscompares++; $display("FAIL rf_fw got %b want 000000", u4_fw); end
  endtask

  initial begin
    R = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_ex_forward();
    test_load_use();
    test_multicycle_load();
    test_flush();
    test_priority_pc();
    test_reset_in_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
